// File: rtl/ucsbece154b_perf_monitor.sv
// Performance monitor for the N-way superscalar core: event counters, halt/timeout
// detection and a registered select/readout port.

module ucsbece154b_perf_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        smp_i,
  input  logic [31:0] pcf_i,
  input  logic [31:0] instrf_i,
  input  logic [31:0] instrd_i,
  input  logic [6:0]  ope_i,
  input  logic        mispredict_i,
  input  logic        takenf_i,
  output logic        ins_o,
  output logic        br_o,
  output logic        brm_o,
  output logic        jmp_o,
  output logic        jmpm_o,
  output logic        qual_o
);
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [6:0]  BR   = 7'b1100011;
  localparam logic [6:0]  JAL  = 7'b1101111;
  localparam logic [6:0]  JALR = 7'b1100111;

  logic [31:0] prev_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        prev_pc_q <= '0;
    else if (clr_i) prev_pc_q <= '0;
    else if (smp_i) prev_pc_q <= pcf_i;
  end

  // A zero word (flushed slot) and the canonical NOP are both bubbles.
  assign ins_o  = (instrd_i != 32'h0) && (instrd_i != NOP);
  assign br_o   = (ope_i == BR);
  assign brm_o  = br_o && mispredict_i;
  assign jmp_o  = (ope_i == JAL) || (ope_i == JALR);
  assign jmpm_o = jmp_o && !takenf_i;
  assign qual_o = (pcf_i == prev_pc_q) && (instrf_i == NOP);
endmodule

module ucsbece154b_perf_monitor #(
  parameter int LANES       = 2,
  parameter int CNT_W       = 32,
  parameter int HALT_REPEAT = 1,
  parameter int MAX_CYCLES  = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               stall_i,
  input  logic [LANES*32-1:0] pcf_i,
  input  logic [LANES*32-1:0] instrf_i,
  input  logic [LANES*32-1:0] instrd_i,
  input  logic [LANES*7-1:0]  ope_i,
  input  logic [LANES-1:0]    mispredict_i,
  input  logic [LANES-1:0]    takenf_i,
  input  logic [2:0]          sel_i,
  output logic [CNT_W-1:0]    rdata_o,
  output logic                halted_o,
  output logic                timeout_o
);
  localparam int NCNT = 7;
  localparam int IW   = $clog2(LANES + 1);
  localparam int HW   = $clog2(HALT_REPEAT + 1) + 1;
  localparam int CW   = (CNT_W > 32) ? CNT_W : 32;
  localparam int SW   = (CNT_W > 10) ? CNT_W : 10;

  localparam int C_CYC  = 0;
  localparam int C_INS  = 1;
  localparam int C_BR   = 2;
  localparam int C_BRM  = 3;
  localparam int C_JMP  = 4;
  localparam int C_JMPM = 5;
  localparam int C_STL  = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [HW-1:0]               hcnt_q, hcnt_d, hcnt_inc;
  logic [NCNT-1:0][CNT_W-1:0]  cnt_q, cnt_d, sat_cnt;
  logic [NCNT-1:0]             ovf_q, ovf_d, sat_ovf;
  logic [NCNT-1:0][IW-1:0]     inc;
  logic [CNT_W:0]              sum [NCNT];
  logic                        timeout_q, timeout_d;
  logic                        halted_q;
  logic [CNT_W-1:0]            rdata_q, rdata_d;
  logic [SW-1:0]               status;
  logic                        smp;

  logic [LANES-1:0] ins_v, br_v, brm_v, jmp_v, jmpm_v, qual_v;
  logic             all_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ucsbece154b_perf_lane u_lane (
      .clk          (clk),
      .rst          (reset),
      .clr_i        (clear_i),
      .smp_i        (smp),
      .pcf_i        (pcf_i[l*32 +: 32]),
      .instrf_i     (instrf_i[l*32 +: 32]),
      .instrd_i     (instrd_i[l*32 +: 32]),
      .ope_i        (ope_i[l*7 +: 7]),
      .mispredict_i (mispredict_i[l]),
      .takenf_i     (takenf_i[l]),
      .ins_o        (ins_v[l]),
      .br_o         (br_v[l]),
      .brm_o        (brm_v[l]),
      .jmp_o        (jmp_v[l]),
      .jmpm_o       (jmpm_v[l]),
      .qual_o       (qual_v[l])
    );
  end

  assign all_q = &qual_v;

  function automatic logic [IW-1:0] popcnt(input logic [LANES-1:0] v);
    popcnt = '0;
    for (int i = 0; i < LANES; i++) popcnt = popcnt + IW'(v[i]);
  endfunction

  always_comb begin
    inc         = '0;
    inc[C_CYC]  = IW'(1);
    inc[C_INS]  = popcnt(ins_v);
    inc[C_BR]   = popcnt(br_v);
    inc[C_BRM]  = popcnt(brm_v);
    inc[C_JMP]  = popcnt(jmp_v);
    inc[C_JMPM] = popcnt(jmpm_v);
    inc[C_STL]  = IW'(stall_i);
  end

  // Lane increments are pre-summed, so one widened add per counter catches any carry-out.
  always_comb begin
    for (int k = 0; k < NCNT; k++) begin
      sum[k]     = {1'b0, cnt_q[k]} + (CNT_W+1)'(inc[k]);
      sat_cnt[k] = sum[k][CNT_W] ? {CNT_W{1'b1}} : sum[k][CNT_W-1:0];
      sat_ovf[k] = ovf_q[k] | sum[k][CNT_W];
    end
  end

  assign hcnt_inc = hcnt_q + HW'(1);

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    timeout_d = timeout_q;
    smp       = 1'b0;
    case (state_q)
      S_IDLE: begin
        smp = 1'b1;
        if (en_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (en_i) begin
          smp    = 1'b1;
          hcnt_d = all_q ? hcnt_inc : '0;
          if (all_q && (hcnt_inc == HW'(HALT_REPEAT))) begin
            state_d = S_HALT;
          end else begin
            cnt_d = sat_cnt;
            ovf_d = sat_ovf;
            if ((MAX_CYCLES != 0) && (CW'(sat_cnt[C_CYC]) == CW'(MAX_CYCLES))) begin
              state_d   = S_HALT;
              timeout_d = 1'b1;
            end
          end
        end
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
    if (clear_i) begin
      state_d   = S_IDLE;
      hcnt_d    = '0;
      cnt_d     = '0;
      ovf_d     = '0;
      timeout_d = 1'b0;
      smp       = 1'b0;
    end
  end

  always_comb begin
    status      = '0;
    status[1:0] = state_q;
    status[2]   = timeout_q;
    status[9:3] = ovf_q;
    rdata_d     = '0;
    case (sel_i)
      3'd0: rdata_d = cnt_q[C_CYC];
      3'd1: rdata_d = cnt_q[C_INS];
      3'd2: rdata_d = cnt_q[C_BR];
      3'd3: rdata_d = cnt_q[C_BRM];
      3'd4: rdata_d = cnt_q[C_JMP];
      3'd5: rdata_d = cnt_q[C_JMPM];
      3'd6: rdata_d = cnt_q[C_STL];
      default: rdata_d = status[CNT_W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= '0;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      halted_q  <= (state_d == S_HALT);
      rdata_q   <= rdata_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign halted_o  = halted_q;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Directed bench for ucsbece154b_perf_monitor: table of counting phases plus
// hand sequences for halt, saturation, async reset, timeout and clear.
module tb_ucsbece154b_perf_monitor;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [6:0]  BR   = 7'b1100011;
  localparam logic [6:0]  JAL  = 7'b1101111;
  localparam logic [6:0]  JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_i = 1'b0, clear_i = 1'b0, stall_i = 1'b0;
  logic [63:0] pcf_i = '0, instrf_i = '0, instrd_i = '0;
  logic [13:0] ope_i = '0;
  logic [1:0]  mispredict_i = '0, takenf_i = '0;
  logic [2:0]  sel_i = '0;
  logic [31:0] rdata_o;
  logic        halted_o, timeout_o;
  logic [3:0]  s_rdata;
  logic        s_halted, s_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] pc = 32'h1000;

  always #5 clk = ~clk;

  ucsbece154b_perf_monitor #(.LANES(2), .CNT_W(32), .HALT_REPEAT(1), .MAX_CYCLES(500)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i), .stall_i(stall_i),
    .pcf_i(pcf_i), .instrf_i(instrf_i), .instrd_i(instrd_i), .ope_i(ope_i),
    .mispredict_i(mispredict_i), .takenf_i(takenf_i), .sel_i(sel_i),
    .rdata_o(rdata_o), .halted_o(halted_o), .timeout_o(timeout_o)
  );

  ucsbece154b_perf_monitor #(.LANES(2), .CNT_W(4), .HALT_REPEAT(1), .MAX_CYCLES(0)) dut_s (
    .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i), .stall_i(stall_i),
    .pcf_i(pcf_i), .instrf_i(instrf_i), .instrd_i(instrd_i), .ope_i(ope_i),
    .mispredict_i(mispredict_i), .takenf_i(takenf_i), .sel_i(sel_i),
    .rdata_o(s_rdata), .halted_o(s_halted), .timeout_o(s_timeout)
  );

  typedef struct {
    logic        clr;
    int          ncyc;
    logic [31:0] id0, id1;
    logic [6:0]  op0, op1;
    logic [1:0]  mp, tk;
    logic        stl;
    logic [31:0] e_cyc, e_ins, e_br, e_brm, e_jmp, e_jmpm, e_stl;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] s);
    sel_i = s;
    tick();
  endtask

  task automatic adv_pc();
    pcf_i = {pc + 32'd4, pc};
    pc    = pc + 32'd8;
  endtask

  task automatic neutral();
    instrd_i = '0; ope_i = '0; mispredict_i = '0; takenf_i = 2'b11; stall_i = 1'b0;
    instrf_i = {ADDI, ADDI};
  endtask

  // Clear, then one enable edge to leave IDLE; counting starts on the following edge.
  task automatic clear_and_start();
    en_i = 1'b0; clear_i = 1'b1; neutral(); tick();
    clear_i = 1'b0; en_i = 1'b1; adv_pc(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 10, ADDI, ADDI, 7'd0, 7'd0, 2'b00, 2'b11, 1'b0, 10, 20, 0, 0, 0, 0, 0};
    vecs[1] = '{1'b1, 5,  NOP,  32'h0, 7'd0, 7'd0, 2'b00, 2'b11, 1'b0, 5, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{1'b0, 3,  ADDI, ADDI, 7'd0, 7'd0, 2'b00, 2'b11, 1'b0, 8, 6, 0, 0, 0, 0, 0};
    vecs[3] = '{1'b1, 1,  NOP,  NOP,  BR,   JAL,  2'b01, 2'b00, 1'b0, 1, 0, 1, 1, 1, 1, 0};
    vecs[4] = '{1'b0, 3,  NOP,  NOP,  BR,   JAL,  2'b00, 2'b10, 1'b0, 4, 0, 4, 1, 4, 1, 0};
    vecs[5] = '{1'b1, 6,  ADDI, ADDI, BR,   JALR, 2'b11, 2'b00, 1'b1, 6, 12, 6, 6, 6, 6, 6};
    vecs[6] = '{1'b0, 2,  ADDI, 32'h0, JALR, JALR, 2'b11, 2'b01, 1'b0, 8, 14, 6, 6, 10, 8, 6};
    vecs[7] = '{1'b0, 1,  32'h1, NOP, 7'b1100010, 7'b1101011, 2'b11, 2'b00, 1'b1, 9, 15, 6, 6, 10, 8, 7};

    neutral();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_halted", {31'h0, halted_o}, 32'h0);
    chk("reset_timeout", {31'h0, timeout_o}, 32'h0);
    rd(3'd7);
    chk("reset_status", rdata_o, 32'h0);

    for (int v = 0; v < 8; v++) begin
      logic [31:0] ex [7];
      ex[0] = vecs[v].e_cyc; ex[1] = vecs[v].e_ins; ex[2] = vecs[v].e_br;
      ex[3] = vecs[v].e_brm; ex[4] = vecs[v].e_jmp; ex[5] = vecs[v].e_jmpm;
      ex[6] = vecs[v].e_stl;
      if (vecs[v].clr) clear_and_start();
      instrd_i     = {vecs[v].id1, vecs[v].id0};
      ope_i        = {vecs[v].op1, vecs[v].op0};
      mispredict_i = vecs[v].mp;
      takenf_i     = vecs[v].tk;
      stall_i      = vecs[v].stl;
      en_i         = 1'b1;
      for (int c = 0; c < vecs[v].ncyc; c++) begin
        adv_pc();
        tick();
      end
      en_i = 1'b0;
      neutral();
      for (int k = 0; k < 7; k++) begin
        rd(3'(k));
        chk($sformatf("vec%0d_sel%0d", v, k), rdata_o, ex[k]);
      end
      chk($sformatf("vec%0d_halted", v), {31'h0, halted_o}, 32'h0);
    end

    // Saturation: narrow instance clamps both cyc and ins at 15.
    clear_and_start();
    instrd_i = {ADDI, ADDI};
    for (int c = 0; c < 16; c++) begin
      adv_pc();
      tick();
    end
    en_i = 1'b0;
    rd(3'd0);
    chk("sat_main_cyc", rdata_o, 32'd16);
    chk("sat_small_cyc", {28'h0, s_rdata}, 32'd15);
    rd(3'd1);
    chk("sat_main_ins", rdata_o, 32'd32);
    chk("sat_small_ins", {28'h0, s_rdata}, 32'd15);
    rd(3'd7);
    chk("sat_small_status", {28'h0, s_rdata}, 32'h9);

    // Halt: 12 counted cycles, the 12th parks on 0x40/0x44, next edge halts.
    clear_and_start();
    instrd_i = {ADDI, ADDI};
    for (int c = 0; c < 11; c++) begin
      adv_pc();
      tick();
    end
    pcf_i    = {32'h44, 32'h40};
    instrf_i = {NOP, NOP};
    tick();
    chk("halt_not_yet", {31'h0, halted_o}, 32'h0);
    tick();
    chk("halt_rise", {31'h0, halted_o}, 32'h1);
    chk("halt_no_timeout", {31'h0, timeout_o}, 32'h0);
    ope_i = {BR, JAL}; stall_i = 1'b1; instrf_i = {ADDI, ADDI};
    for (int c = 0; c < 3; c++) begin
      adv_pc();
      tick();
    end
    rd(3'd0);
    chk("halt_cyc_frozen", rdata_o, 32'd12);
    rd(3'd1);
    chk("halt_ins_frozen", rdata_o, 32'd24);
    rd(3'd6);
    chk("halt_stl_frozen", rdata_o, 32'd0);
    rd(3'd7);
    chk("halt_status", rdata_o, 32'h2);
    chk("halt_held", {31'h0, halted_o}, 32'h1);

    // Asynchronous reset in the middle of a cycle.
    rd(3'd0);
    chk("pre_reset_rdata", rdata_o, 32'd12);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_rdata", rdata_o, 32'h0);
    chk("areset_halted", {31'h0, halted_o}, 32'h0);
    chk("areset_small_rdata", {28'h0, s_rdata}, 32'h0);
    #1;
    reset = 1'b0;
    tick();

    // Timeout at 500 counted cycles, then clear.
    clear_and_start();
    instrd_i = {ADDI, ADDI};
    begin
      int n;
      n = 0;
      while (!timeout_o && n < 600) begin
        adv_pc();
        tick();
        n++;
      end
      chk("timeout_cycles", n, 32'd500);
    end
    chk("timeout_flag", {31'h0, timeout_o}, 32'h1);
    chk("timeout_halted", {31'h0, halted_o}, 32'h1);
    en_i = 1'b0;
    rd(3'd0);
    chk("timeout_cyc", rdata_o, 32'd500);
    rd(3'd7);
    chk("timeout_status", rdata_o, 32'h6);
    clear_i = 1'b1;
    tick();
    chk("clear_edge_rdata", rdata_o, 32'h6);
    clear_i = 1'b0;
    tick();
    chk("clear_status", rdata_o, 32'h0);
    chk("clear_halted", {31'h0, halted_o}, 32'h0);
    chk("clear_timeout", {31'h0, timeout_o}, 32'h0);
    rd(3'd0);
    chk("clear_cyc", rdata_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
